// File: rtl/my_computer_pkg.sv
// rtl/my_computer_pkg.sv - opcodes, instruction fields and program ROM for my_computer
//
// Shared by the CPU core and the top. Holds the opcode enum, the bit
// positions of the instruction fields and the fixed program ROM contents.
package my_computer_pkg;

    localparam int DATA_W = 8;
    localparam int PC_W   = 5;
    localparam int INSN_W = 16;

    // Instruction layout: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_ADDI = 4'h7,
        OP_IN   = 4'h8,
        OP_OUT  = 4'h9,
        OP_DISP = 4'hA,
        OP_JMP  = 4'hB,
        OP_JZ   = 4'hC,
        OP_JNZ  = 4'hD,
        OP_HALT = 4'hE,
        OP_NOPF = 4'hF
    } opcode_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } cpu_state_t;

    // Countdown demo: emits R0 = 5..1 on OUT/DISP, then reads SW into R2,
    // outputs it and halts. Every other word is a NOP.
    function automatic logic [INSN_W-1:0] rom_word(input logic [PC_W-1:0] addr);
        logic [INSN_W-1:0] w;
        case (addr)
            5'd0:    w = 16'h1005;   // LDI  R0, 5
            5'd1:    w = 16'h1401;   // LDI  R1, 1
            5'd2:    w = 16'h9000;   // OUT  R0
            5'd3:    w = 16'hA000;   // DISP R0
            5'd4:    w = 16'h3100;   // SUB  R0, R1
            5'd5:    w = 16'hD002;   // JNZ  2
            5'd6:    w = 16'h8800;   // IN   R2
            5'd7:    w = 16'h9800;   // OUT  R2
            5'd8:    w = 16'hE000;   // HALT
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/my_computer_if.sv
// rtl/my_computer_if.sv - board-side I/O bundle (switches, keys, LEDs, hex digits)
//
// master : the board / stimulus side, drives sw and key, watches ledr and hex
// slave  : the CPU side, reads sw and key, drives ledr and the six digits
interface my_computer_if;
    logic [9:0] sw;
    logic [3:0] key;
    logic [9:0] ledr;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic [6:0] hex4;
    logic [6:0] hex5;

    modport master (
        output sw, key,
        input  ledr, hex0, hex1, hex2, hex3, hex4, hex5
    );

    modport slave (
        input  sw, key,
        output ledr, hex0, hex1, hex2, hex3, hex4, hex5
    );
endinterface

// File: rtl/my_computer_core.sv
// rtl/my_computer_core.sv - single-cycle 8-bit CPU with ROM, registers and display decode
//
// Ports:
//   clk   : sole clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (board switch SW[8])
//   io    : board I/O (slave side): sw[7:0] data in, ledr = {halted, z, out},
//           hex1:hex0 = display register, hex3:hex2 = {3'b000, pc}, hex5:hex4 = R0
module my_computer_core
    import my_computer_pkg::*;
#(
    parameter int PROG_DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    my_computer_if.slave  io
);

    cpu_state_t          state, state_nxt;
    logic [PC_W-1:0]     pc, pc_nxt;
    logic [DATA_W-1:0]   regs [4];
    logic [DATA_W-1:0]   regs_nxt [4];
    logic                z, z_nxt;
    logic [DATA_W-1:0]   out_reg, out_nxt;
    logic [DATA_W-1:0]   disp, disp_nxt;

    logic [INSN_W-1:0]   instr;
    opcode_t             op;
    logic [1:0]          rd, rs;
    logic [DATA_W-1:0]   imm, a, b, res;
    logic                wr_res;

    // KEY and SW[9] are reserved; SW[8] arrives separately as rst_n.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, io.key, io.sw[9:8]};

    assign instr = (int'(pc) < PROG_DEPTH) ? rom_word(pc) : '0;
    assign op    = opcode_t'(instr[OP_MSB:OP_LSB]);
    assign rd    = instr[RD_MSB:RD_LSB];
    assign rs    = instr[RS_MSB:RS_LSB];
    assign imm   = instr[IMM_MSB:IMM_LSB];
    assign a     = regs[rd];
    assign b     = regs[rs];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            pc      <= '0;
            regs    <= '{default: '0};
            z       <= 1'b0;
            out_reg <= '0;
            disp    <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            regs    <= regs_nxt;
            z       <= z_nxt;
            out_reg <= out_nxt;
            disp    <= disp_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc + 1'b1;
        regs_nxt  = regs;
        z_nxt     = z;
        out_nxt   = out_reg;
        disp_nxt  = disp;
        res       = '0;
        wr_res    = 1'b0;

        if (state == ST_HALT) begin
            // Frozen until reset; everything holds, including the PC.
            pc_nxt = pc;
        end else begin
            case (op)
                OP_LDI:  regs_nxt[rd] = imm;
                OP_ADD:  begin res = a + b;    wr_res = 1'b1; end
                OP_SUB:  begin res = a - b;    wr_res = 1'b1; end
                OP_AND:  begin res = a & b;    wr_res = 1'b1; end
                OP_OR:   begin res = a | b;    wr_res = 1'b1; end
                OP_XOR:  begin res = a ^ b;    wr_res = 1'b1; end
                OP_ADDI: begin res = a + imm;  wr_res = 1'b1; end
                OP_IN:   begin res = io.sw[7:0]; wr_res = 1'b1; end
                OP_OUT:  out_nxt  = a;
                OP_DISP: disp_nxt = a;
                OP_JMP:  pc_nxt = imm[PC_W-1:0];
                OP_JZ:   if (z)  pc_nxt = imm[PC_W-1:0];
                OP_JNZ:  if (!z) pc_nxt = imm[PC_W-1:0];
                OP_HALT: state_nxt = ST_HALT;
                default: ;
            endcase

            // Only the ALU/IN group touches Z; LDI writes rd without it.
            if (wr_res) begin
                regs_nxt[rd] = res;
                z_nxt        = (res == '0);
            end
        end
    end

    logic [6:0] seg [6];

    hex7seg u_hex0 (.digit(disp[3:0]),          .seg(seg[0]));
    hex7seg u_hex1 (.digit(disp[7:4]),          .seg(seg[1]));
    hex7seg u_hex2 (.digit(pc[3:0]),            .seg(seg[2]));
    hex7seg u_hex3 (.digit({3'b000, pc[4]}),    .seg(seg[3]));
    hex7seg u_hex4 (.digit(regs[0][3:0]),       .seg(seg[4]));
    hex7seg u_hex5 (.digit(regs[0][7:4]),       .seg(seg[5]));

    assign io.ledr = {(state == ST_HALT), z, out_reg};
    assign io.hex0 = seg[0];
    assign io.hex1 = seg[1];
    assign io.hex2 = seg[2];
    assign io.hex3 = seg[3];
    assign io.hex4 = seg[4];
    assign io.hex5 = seg[5];

endmodule

// File: rtl/my_computer_hex7seg.sv
// rtl/my_computer_hex7seg.sv - 4-bit to active-low 7-segment glyph decoder
//
// Ports:
//   digit : 4-bit value 0-F
//   seg   : active-low segments, bit0 = a ... bit6 = g
module hex7seg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/my_computer.sv
// rtl/my_computer.sv - board-level top: wires switches/LEDs/digits to the CPU core
//
// Ports:
//   clk       : sole clock
//   LEDR[9:0] : [7:0] OUT register, [8] Z flag, [9] halted
//   SW[9:0]   : [8] async active-low reset, [7:0] data input, [9] unused
//   KEY[3:0]  : reserved, ignored
//   HEX0..5   : active-low 7-segment digits (bit0 = a .. bit6 = g)
module my_computer #(
    parameter int PROG_DEPTH = 32
) (
    input  logic       clk,
    output logic [9:0] LEDR,
    input  logic [9:0] SW,
    input  logic [3:0] KEY,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    my_computer_if io ();

    assign io.sw  = SW;
    assign io.key = KEY;

    my_computer_core #(
        .PROG_DEPTH(PROG_DEPTH)
    ) u_core (
        .clk   (clk),
        .rst_n (SW[8]),
        .io    (io)
    );

    assign LEDR = io.ledr;
    assign HEX0 = io.hex0;
    assign HEX1 = io.hex1;
    assign HEX2 = io.hex2;
    assign HEX3 = io.hex3;
    assign HEX4 = io.hex4;
    assign HEX5 = io.hex5;

endmodule

// File: tb/tb_my_computer.sv
// tb/tb_my_computer.sv - self-checking bench for my_computer
module tb_my_computer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    my_computer_if bus ();

    my_computer dut (
        .clk  (clk),
        .LEDR (bus.ledr),
        .SW   (bus.sw),
        .KEY  (bus.key),
        .HEX0 (bus.hex0),
        .HEX1 (bus.hex1),
        .HEX2 (bus.hex2),
        .HEX3 (bus.hex3),
        .HEX4 (bus.hex4),
        .HEX5 (bus.hex5)
    );

    typedef struct {
        int         edge_n;
        logic [9:0] ledr;
    } exp_t;

    exp_t       sb [$];
    int         total = 0;
    int         bad   = 0;
    int         edges = 0;
    logic [7:0] prev_out = 8'h00;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int edge_n, input logic [9:0] ledr);
        exp_t e;
        e.edge_n = edge_n;
        e.ledr   = ledr;
        sb.push_back(e);
    endtask

    // Every change of the OUT register must match the head of the scoreboard.
    task automatic observe();
        exp_t e;
        if (bus.ledr[7:0] !== prev_out) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("out_edge", 32'(edges), 32'(e.edge_n));
                chk("out_ledr", {22'b0, bus.ledr}, {22'b0, e.ledr});
            end
            prev_out = bus.ledr[7:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edges++;
        #1;
        observe();
        bus.key = 4'($urandom_range(0, 15));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_ledr"}, {22'b0, bus.ledr}, 32'h0);
        chk({tag, "_hex0"}, {25'b0, bus.hex0}, {25'b0, glyph[0]});
        chk({tag, "_hex1"}, {25'b0, bus.hex1}, {25'b0, glyph[0]});
        chk({tag, "_hex2"}, {25'b0, bus.hex2}, {25'b0, glyph[0]});
        chk({tag, "_hex3"}, {25'b0, bus.hex3}, {25'b0, glyph[0]});
        chk({tag, "_hex4"}, {25'b0, bus.hex4}, {25'b0, glyph[0]});
        chk({tag, "_hex5"}, {25'b0, bus.hex5}, {25'b0, glyph[0]});
    endtask

    initial begin
        bus.sw  = 10'h000;
        bus.key = 4'h0;

        // Held in reset across several edges.
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");

        // Countdown program: OUT at edges 3,7,11,15,19, IN/OUT R2 at 23/24, HALT at 25.
        push(3,  10'h005);
        push(7,  10'h004);
        push(11, 10'h003);
        push(15, 10'h002);
        push(19, 10'h001);
        push(24, 10'h0A5);
        @(negedge clk);
        bus.sw = 10'h100;
        edges  = 0;
        for (int i = 0; i < 30; i++) begin
            if (edges == 22) bus.sw[7:0] = 8'hA5;
            tick();
            if (edges == 4) begin
                chk("disp5_hex0", {25'b0, bus.hex0}, {25'b0, glyph[5]});
                chk("disp5_hex1", {25'b0, bus.hex1}, {25'b0, glyph[0]});
            end
            if (edges == 22) begin
                chk("exit_ledr", {22'b0, bus.ledr}, 32'h101);
                chk("exit_hex4", {25'b0, bus.hex4}, {25'b0, glyph[0]});
                chk("exit_hex5", {25'b0, bus.hex5}, {25'b0, glyph[0]});
            end
            if (edges == 25) begin
                chk("halt_ledr", {22'b0, bus.ledr}, 32'h2A5);
            end
        end
        // Five more edges with KEY toggling: nothing may move.
        chk("frozen_ledr", {22'b0, bus.ledr}, 32'h2A5);
        chk("frozen_hex2", {25'b0, bus.hex2}, {25'b0, glyph[9]});
        chk("frozen_hex3", {25'b0, bus.hex3}, {25'b0, glyph[0]});
        chk("frozen_hex0", {25'b0, bus.hex0}, {25'b0, glyph[1]});
        chk("frozen_hex1", {25'b0, bus.hex1}, {25'b0, glyph[0]});
        chk("frozen_hex4", {25'b0, bus.hex4}, {25'b0, glyph[0]});
        chk("sb_drained_run", 32'(sb.size()), 32'd0);

        // Restart, then reset asynchronously in the middle of the loop.
        bus.sw = 10'h000;
        #1;
        check_cleared("halt_reset");
        prev_out = bus.ledr[7:0];
        @(negedge clk);
        bus.sw = 10'h100;
        edges  = 0;
        push(3, 10'h005);
        push(7, 10'h004);
        repeat (10) tick();
        chk("mid_hex0_before", {25'b0, bus.hex0}, {25'b0, glyph[4]});
        #1;
        bus.sw[8] = 1'b0;
        #1;
        check_cleared("mid_reset");
        prev_out = bus.ledr[7:0];
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.sw[8] = 1'b1;
        edges     = 0;
        push(3, 10'h005);
        repeat (4) tick();
        chk("restart_hex0", {25'b0, bus.hex0}, {25'b0, glyph[5]});
        chk("sb_drained_restart", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
